// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Optional input digit check is enabled with BCD2BIN_CHECK_EN.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] DABBLE_THRESH = 4'd8;
    localparam logic [3:0] DABBLE_CORR   = 4'd3;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble digit correction: subtract 3 from any digit >= 8.
module bcd_sub3
    import bcd2bin_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= DABBLE_THRESH) ? digit - DABBLE_CORR : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble step per clock.
// Define BCD2BIN_CHECK_EN to reject inputs holding a digit above 9.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int DW = 4 * DIGITS;
    localparam int W  = DW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    state_t          state;
    state_t          nxt;
    logic [W-1:0]    work;
    logic [W-1:0]    shifted;
    logic [DW-1:0]   fixed;
    logic [CW-1:0]   cnt;
    logic            bad_in;
    logic            bad_q;

    assign shifted = work >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_sub3 u_sub3 (
            .digit (shifted[BIN_W + 4*g +: 4]),
            .fixed (fixed[4*g +: 4])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad_in = bad_in | digit_bad(bcd_in[4*i +: 4]);
        end
    end
`else
    assign bad_in = 1'b0;
    assign err    = 1'b0;
`endif

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt = bad_in ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(BIN_W - 1)) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            cnt     <= '0;
            bad_q   <= 1'b0;
            bin_out <= '0;
            done    <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= {bcd_in, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        bad_q <= bad_in;
                    end
                end
                SHIFT: begin
                    work <= {fixed, shifted[BIN_W-1:0]};
                    cnt  <= cnt + CW'(1);
                end
                DONE: begin
                    // Rejected input reports zero rather than stale work bits
                    bin_out <= bad_q ? '0 : work[BIN_W-1:0];
                    done    <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
                    err     <= bad_q;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (DIGITS=3, BIN_W=10).
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;
    int overlap    = 0;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Caller is #1 after an edge with the DUT idle; lat counts the accepting edge as 1
    task automatic convert(input string tag, input logic [11:0] bcd,
                           input int exp_bin, input int exp_lat,
                           input logic exp_err, input bit chk_bin);
        int  lat;
        bit  got;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'h468;
        check({tag, "_busy"}, 32'(busy), 32'(exp_lat > 2));
        lat = 1;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            got = done;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (chk_bin) check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int vals [10] = '{0, 1, 9, 10, 99, 100, 512, 873, 999, 305};
        int lat;
        bit got;
        int seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 12'h000;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bin",  32'(bin_out), 0);
        check("rst_err",  32'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        convert("h999", 12'h999, 999, 12, 1'b0, 1'b1);
        convert("h000", 12'h000, 0,   12, 1'b0, 1'b1);
        convert("h255", 12'h255, 255, 12, 1'b0, 1'b1);
        convert("h010", 12'h010, 10,  12, 1'b0, 1'b1);

        // Back-to-back with start held, garbage on bcd_in while busy
        start  = 1'b1;
        bcd_in = to_bcd(vals[0]);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bcd_in = 12'($urandom);
            lat = 1;
            got = 1'b0;
            while (!got && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
                got = done;
            end
            check("b2b_period", 32'(lat), 12);
            check("b2b_bin", 32'(bin_out), 32'(vals[i]));
            if (i < 9) bcd_in = to_bcd(vals[i + 1]);
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of an h999 conversion
        start  = 1'b1;
        bcd_in = 12'h999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_bin",  32'(bin_out), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("post_rst_nodone", 32'(seen), 0);
        convert("h123", 12'h123, 123, 12, 1'b0, 1'b1);

`ifdef BCD2BIN_CHECK_EN
        convert("h1A5", 12'h1A5, 0, 2, 1'b1, 1'b1);
        convert("h042", 12'h042, 42, 12, 1'b0, 1'b1);
`else
        convert("h1A5", 12'h1A5, 0, 12, 1'b0, 1'b0);
        convert("h042", 12'h042, 42, 12, 1'b0, 1'b1);
`endif

        check("busy_done_overlap", 32'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
